// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
// fetch_unit : PC + ROM address generator with registered valid/ready output
// Revision   : 1.0
// =============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        instr_fault,
    output logic        halted
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // 33 bits so that ROM_DEPTH up to 2^30 compares without truncation
    localparam logic [32:0] DEPTH_W = 33'(ROM_DEPTH);

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        fire;
    logic        in_range;

    assign address  = pc;
    assign halted   = (state == ST_HALT);
    assign in_range = ({3'b000, pc[31:2]} < DEPTH_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fire       = (state == ST_RUN) && fetch_en && !redirect_valid &&
                     (!instr_valid || instr_ready);
        if (redirect_valid) begin
            state_next = ST_RUN;
        end else if (fire && !in_range) begin
            state_next = ST_HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= {RESET_PC[31:2], 2'b00};
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
        end else if (redirect_valid) begin
            // Flush wins over any fetch; a coincident handshake is simply dropped
            pc          <= {redirect_pc[31:2], 2'b00};
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
        end else if (fire) begin
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (in_range) begin
                instr       <= data_in;
                instr_fault <= 1'b0;
                pc          <= pc + 32'd4;
            end else begin
                instr       <= 32'h0;
                instr_fault <= 1'b1;
            end
        end else if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
// tb_fetch_unit : directed self-checking bench with a 256-word ROM model
// Revision      : 1.0
// =============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_fault;
    logic        halted;

    int checks;
    int failures;

    logic [31:0] rom [0:255];

    // Word i holds i+1; beyond the ROM the bus reads a distinct garbage value
    assign data_in = (address[31:10] == 22'h0) ? rom[address[9:2]] : 32'hBAD0_BAD0;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .ROM_DEPTH (256)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .address        (address),
        .data_in        (data_in),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_fault    (instr_fault),
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] i,
                           input logic [31:0] p, input logic f);
        chk({tag, "_valid"}, {31'h0, instr_valid}, {31'h0, v});
        if (v) begin
            chk({tag, "_instr"}, instr, i);
            chk({tag, "_pc"},    instr_pc, p);
            chk({tag, "_fault"}, {31'h0, instr_fault}, {31'h0, f});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 256; k++) rom[k] = 32'(k + 1);

        rst_n          = 1'b0;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;
        #12;
        chk("rst_valid",  {31'h0, instr_valid}, 32'h0);
        chk("rst_fault",  {31'h0, instr_fault}, 32'h0);
        chk("rst_halted", {31'h0, halted}, 32'h0);
        chk("rst_instr",  instr, 32'h0);
        chk("rst_ipc",    instr_pc, 32'h0);
        chk("rst_addr",   address, 32'h0);
        rst_n = 1'b1;
        step();
        chk("idle_valid", {31'h0, instr_valid}, 32'h0);

        // Streaming: one word per cycle
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        step(); chk_out("s0", 1'b1, 32'd1, 32'd0, 1'b0); chk("s0_addr", address, 32'd4);
        step(); chk_out("s1", 1'b1, 32'd2, 32'd4, 1'b0); chk("s1_addr", address, 32'd8);

        // Stall: everything holds
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("stall", 1'b1, 32'd2, 32'd4, 1'b0);
            chk("stall_addr", address, 32'd8);
        end
        instr_ready = 1'b1;
        step(); chk_out("rel", 1'b1, 32'd3, 32'd8, 1'b0); chk("rel_addr", address, 32'd12);

        // Redirect colliding with a handshake: word 3 consumed, flush, no fetch
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_000F;
        step();
        chk("rd_valid", {31'h0, instr_valid}, 32'h0);
        chk("rd_addr",  address, 32'd12);
        redirect_valid = 1'b0;
        step(); chk_out("rd1", 1'b1, 32'd4, 32'd12, 1'b0); chk("rd1_addr", address, 32'd16);

        // fetch_en low: pending word still drains, nothing new fetched
        fetch_en = 1'b0;
        step(); chk("fe0_valid", {31'h0, instr_valid}, 32'h0); chk("fe0_addr", address, 32'd16);
        step(); chk("fe1_valid", {31'h0, instr_valid}, 32'h0); chk("fe1_addr", address, 32'd16);
        fetch_en = 1'b1;

        // Out of range: last word, then fault and halt
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_03FC;
        step(); chk("or_addr", address, 32'h3FC); chk("or_valid", {31'h0, instr_valid}, 32'h0);
        redirect_valid = 1'b0;
        step(); chk_out("last", 1'b1, 32'd256, 32'd1020, 1'b0); chk("last_halt", {31'h0, halted}, 32'h0);
        step(); chk_out("flt", 1'b1, 32'd0, 32'd1024, 1'b1);
        chk("flt_halt", {31'h0, halted}, 32'h1);
        chk("flt_addr", address, 32'd1024);
        instr_ready = 1'b0;
        step(); chk_out("flt_hold", 1'b1, 32'd0, 32'd1024, 1'b1);
        instr_ready = 1'b1;
        step(); chk("flt_drain", {31'h0, instr_valid}, 32'h0); chk("h_halt", {31'h0, halted}, 32'h1);
        step(); chk("h_nofire", {31'h0, instr_valid}, 32'h0); chk("h_addr", address, 32'd1024);

        // Redirect out of HALT
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step(); chk("unh_halt", {31'h0, halted}, 32'h0); chk("unh_addr", address, 32'h0);
        chk("unh_fault", {31'h0, instr_fault}, 32'h0);
        redirect_valid = 1'b0;
        step(); chk_out("unh1", 1'b1, 32'd1, 32'd0, 1'b0);

        // Async reset in the middle of a stall, between clock edges
        instr_ready = 1'b0;
        step(); chk_out("pre_rst", 1'b1, 32'd1, 32'd0, 1'b0); chk("pre_rst_addr", address, 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'h0, instr_valid}, 32'h0);
        chk("ar_addr",  address, 32'h0);
        chk("ar_instr", instr, 32'h0);
        #3 rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of rom_module.
- Holds the program counter and drives the ROM's 32-bit word address.
- Captures the combinational ROM data_out into a registered instruction output, presented to decode with a valid/ready handshake.
- Supports stalls, branch redirects and out-of-range fault/halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits forced to 0.
- ROM_DEPTH, 256, number of 32-bit words in the attached ROM; word index pc[31:2] >= ROM_DEPTH is out of range.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_en  input  1  enables fetching; when low no new fetch fires, outputs hold.
- redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
- redirect_pc  input  32  redirect target; bits [1:0] ignored.
- address  output  32  to ROM address input; equals pc register, combinational from it.
- data_in  input  32  from ROM data_out; combinational read of address.
- instr  output  32  registered instruction word.
- instr_pc  output  32  PC of instr.
- instr_valid  output  1  instr/instr_pc/instr_fault valid.
- instr_ready  input  1  decode accepts when instr_valid && instr_ready.
- instr_fault  output  1  marks the current output as an out-of-range fetch.
- halted  output  1  high while in HALT state.

Behaviour:
- Reset (rst_n low, async):
  - pc = {RESET_PC[31:2],2'b00}.
  - instr = 0, instr_pc = 0, instr_valid = 0, instr_fault = 0.
  - state = RUN, halted = 0.
- Alignment: pc[1:0] always 0; address[1:0] always 0.
- States: RUN, HALT.
  - halted = (state == HALT), registered.
- fire = (state == RUN) && fetch_en && !redirect_valid && (!instr_valid || instr_ready).
- On fire, in range (pc[31:2] < ROM_DEPTH):
  - instr <= data_in, instr_pc <= pc, instr_valid <= 1, instr_fault <= 0.
  - pc <= pc + 4, 32-bit modulo.
- On fire, out of range:
  - instr <= 0, instr_pc <= pc, instr_valid <= 1, instr_fault <= 1.
  - pc unchanged, state <= HALT.
- No fire, RUN or HALT:
  - If instr_valid && instr_ready, instr_valid <= 0 (output consumed, nothing replaces it).
  - Otherwise all outputs hold.
- Stall: instr_valid && !instr_ready holds instr, instr_pc, instr_fault and pc stable for any number of cycles.
- Redirect (redirect_valid high), highest priority, any state:
  - pc <= {redirect_pc[31:2],2'b00}; instr_valid <= 0 (flush); instr_fault <= 0; state <= RUN.
  - No fetch fires in the redirect cycle.
  - A handshake coinciding with redirect still counts as consumed by decode.
  - First post-redirect instruction appears with instr_valid = 1 one cycle after the redirect, provided it fires then.
- Latency: fire at edge N puts instr valid after edge N.
  - Throughput is 1 instruction per cycle with instr_ready held high.
- fetch_en low: no fire; a valid output still completes its handshake.
- HALT: no fetch until redirect; a pending fault output still needs a handshake to clear.
- PC wrap: 32'hFFFF_FFFC + 4 = 0. Out-of-range detection takes precedence, so the wrap is only reachable if ROM_DEPTH = 2^30.
- Reset mid-stall or mid-redirect: immediate return to reset values; no partial update.

Test Plan:
- Reset, then fetch_en = 1, instr_ready = 1, ROM words 0..4 = 1..5 -> instr 1,2,3,4,5 on consecutive cycles with instr_pc 0,4,8,12,16; address advances by 4 each cycle.
- Stall: instr_ready = 0 for 3 cycles while instr = 2 (instr_pc = 4) -> instr, instr_pc and address = 8 all hold; on release the next instr is 3 at pc 8.
- Redirect: redirect_valid pulse with redirect_pc = 32'h0000_000F while streaming -> instr_valid = 0 the next cycle; the following cycle gives instr = 4, instr_pc = 12.
- Redirect collides with a handshake (instr_valid = instr_ready = 1) -> current word accepted once; no extra fetch that cycle; flush applied.
- Out of range: redirect to 32'h0000_03FC (word 255) then run -> word 255 delivered at pc 1020; next output has instr_fault = 1, instr = 0, instr_pc = 1024; halted = 1; no further fires. A redirect to 0 clears halted, and instr = 1 follows.
- Async reset asserted mid-stall between clock edges -> instr_valid = 0, address = RESET_PC immediately, without waiting for a clk edge.
